// File: rtl/inst_prefetch_pkg.sv
// Shared types and constants for the instruction prefetch stage.
// Defining IPF_PERF_EN adds fetch/flush performance counters to inst_prefetch.
package inst_prefetch_pkg;

  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned InstBus     = 32;

  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic        ChipEnable  = 1'b1;
  localparam logic        ChipDisable = 1'b0;

  typedef enum logic [1:0] {
    IpfBoot = 2'd0,
    IpfRun  = 2'd1,
    IpfHold = 2'd2
  } ipf_state_e;

  function automatic logic [InstAddrBus-1:0] word_align(input logic [InstAddrBus-1:0] addr);
    return {addr[InstAddrBus-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_prefetch_if.sv
// ROM port, decode-side handshake and redirect bundle of the prefetch stage.
// master: the prefetch stage; slave: the ROM/CPU environment around it.
interface inst_prefetch_if;
  import inst_prefetch_pkg::*;

  logic                   rom_ce_o;
  logic [InstAddrBus-1:0] rom_addr_o;
  logic [InstBus-1:0]     rom_data_i;
  logic                   if_valid_o;
  logic [InstAddrBus-1:0] if_pc_o;
  logic [InstBus-1:0]     if_inst_o;
  logic                   id_ready_i;
  logic                   redirect_i;
  logic [InstAddrBus-1:0] redirect_pc_i;

  modport master (
    output rom_ce_o, rom_addr_o, if_valid_o, if_pc_o, if_inst_o,
    input  rom_data_i, id_ready_i, redirect_i, redirect_pc_i
  );

  modport slave (
    input  rom_ce_o, rom_addr_o, if_valid_o, if_pc_o, if_inst_o,
    output rom_data_i, id_ready_i, redirect_i, redirect_pc_i
  );

endinterface

// File: rtl/inst_prefetch_queue.sv
// DEPTH-entry register FIFO of {pc, inst} pairs (the ipf_queue of the prefetch stage).
// Flush wins over push/pop; the head reads as zero when empty.
module inst_prefetch_queue
  import inst_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [InstAddrBus-1:0] push_pc_i,
  input  logic [InstBus-1:0]     push_inst_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [InstAddrBus-1:0] head_pc_o,
  output logic [InstBus-1:0]     head_inst_o,
  output logic [CntW-1:0]        count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  logic [InstAddrBus-1:0] pc_mem_q   [DEPTH];
  logic [InstBus-1:0]     inst_mem_q [DEPTH];
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]        count_q, count_d;
  logic                   push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  assign push_ok = push_i & ~full_o & ~flush_i;
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      pc_mem_q[wr_ptr_q]   <= push_pc_i;
      inst_mem_q[wr_ptr_q] <= push_inst_i;
    end
  end

  assign head_pc_o   = empty_o ? ZeroWord : pc_mem_q[rd_ptr_q];
  assign head_inst_o = empty_o ? ZeroWord : inst_mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetch stage: owns the fetch PC, drives the ROM and queues fetched words.
// Optional IPF_PERF_EN adds perf_fetch_cnt_o / perf_flush_cnt_o counters.
module inst_prefetch
  import inst_prefetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  inst_prefetch_if.master       bus
`ifdef IPF_PERF_EN
  ,
  output logic [31:0]           perf_fetch_cnt_o,
  output logic [31:0]           perf_flush_cnt_o
`endif
);

  localparam int unsigned CntW = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1;

  ipf_state_e             state_q, state_d;
  logic [InstAddrBus-1:0] fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0]        count;
  logic                   full, empty, fetch, pop;

  assign fetch = (state_q == IpfRun) && !full && !bus.redirect_i;
  assign pop   = !empty && bus.id_ready_i;

  assign bus.rom_ce_o   = fetch ? ChipEnable : ChipDisable;
  assign bus.rom_addr_o = fetch ? fetch_pc_q : ZeroWord;
  assign bus.if_valid_o = !empty;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (bus.redirect_i) begin
      state_d    = IpfRun;
      fetch_pc_d = word_align(bus.redirect_pc_i);
    end else begin
      unique case (state_q)
        IpfBoot: state_d = IpfRun;
        // Only a push without a pop can fill the last free slot.
        IpfRun:  if (fetch && !pop && count == CntW'(DEPTH - 1)) state_d = IpfHold;
        IpfHold: if (pop) state_d = IpfRun;
        default: state_d = IpfBoot;
      endcase
      if (fetch) fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IpfBoot;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  inst_prefetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fetch),
    .push_pc_i   (fetch_pc_q),
    .push_inst_i (bus.rom_data_i),
    .pop_i       (pop),
    .flush_i     (bus.redirect_i),
    .head_pc_o   (bus.if_pc_o),
    .head_inst_o (bus.if_inst_o),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty)
  );

`ifdef IPF_PERF_EN
  logic [31:0] perf_fetch_q, perf_flush_q;
  logic        discard;

  // A popped head is delivered, so a flush only counts if something else was queued.
  assign discard = bus.redirect_i && (count > CntW'(pop));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_q + 32'(fetch);
      perf_flush_q <= perf_flush_q + 32'(discard);
    end
  end

  assign perf_fetch_cnt_o = perf_fetch_q;
  assign perf_flush_cnt_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_inst_prefetch.sv
// Randomized bench for inst_prefetch against a queue-based reference model.
// Uses RESET_PC near the top of the address space so every restart exercises PC wrap.
module tb_inst_prefetch;
  import inst_prefetch_pkg::*;

  localparam logic [31:0] RstPc = 32'hFFFF_FFF8;
  localparam int          Depth = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  inst_prefetch_if bus ();

`ifdef IPF_PERF_EN
  logic [31:0] perf_fetch, perf_flush;
`endif

  inst_prefetch #(
    .RESET_PC (RstPc),
    .DEPTH    (Depth)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef IPF_PERF_EN
    ,
    .perf_fetch_cnt_o (perf_fetch),
    .perf_flush_cnt_o (perf_flush)
`endif
  );

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return 32'h1000_0000 + {2'b00, addr[31:2]};
  endfunction

  assign bus.rom_data_i = rom_word(bus.rom_addr_o);

  // Reference model state
  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_boot;
  logic [31:0] m_fetches, m_flushes;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc      = RstPc;
    m_boot    = 1'b1;
    m_fetches = '0;
    m_flushes = '0;
  endtask

  function automatic bit model_fetch(input bit redir);
    return !m_boot && (mq.size() < Depth) && !redir;
  endfunction

  task automatic check_outputs(input bit redir);
    bit ce;
    ce = model_fetch(redir);
    check_eq("rom_ce", 32'(bus.rom_ce_o), 32'(ce));
    check_eq("rom_addr", bus.rom_addr_o, ce ? m_pc : 32'h0);
    check_eq("if_valid", 32'(bus.if_valid_o), 32'(mq.size() != 0));
    check_eq("if_pc", bus.if_pc_o, (mq.size() != 0) ? mq[0].pc : 32'h0);
    check_eq("if_inst", bus.if_inst_o, (mq.size() != 0) ? mq[0].inst : 32'h0);
`ifdef IPF_PERF_EN
    check_eq("perf_fetch", perf_fetch, m_fetches);
    check_eq("perf_flush", perf_flush, m_flushes);
`endif
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model at the rising edge.
  task automatic step(input bit ready, input bit redir, input logic [31:0] rpc);
    bit ce, pop;
    bus.id_ready_i    = ready;
    bus.redirect_i    = redir;
    bus.redirect_pc_i = rpc;
    #1;
    check_outputs(redir);
    ce  = model_fetch(redir);
    pop = (mq.size() != 0) && ready;
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (redir) begin
      if (mq.size() != 0) m_flushes++;
      mq.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else if (ce) begin
      mq.push_back('{pc: m_pc, inst: rom_word(m_pc)});
      m_pc = m_pc + 32'd4;
      m_fetches++;
    end
    m_boot = 1'b0;
    @(negedge clk);
  endtask

  // Assert reset between clock edges, check outputs clear at once, release at the next fall.
  task automatic reset_pulse();
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs(bus.redirect_i);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bus.id_ready_i    = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    model_reset();
    #2;
    check_outputs(1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Streaming with a ready consumer, wrapping past 0xFFFF_FFFC
    repeat (12) step(1'b1, 1'b0, 32'h0);

    // Fill to hold, single pop, then fetch resumes
    reset_pulse();
    repeat (8) step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    repeat (4) step(1'b0, 1'b0, 32'h0);

    // Redirect with three queued entries and a simultaneous pop
    reset_pulse();
    repeat (4) step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0103);
    repeat (2) step(1'b0, 1'b0, 32'h0);
    repeat (3) step(1'b1, 1'b0, 32'h0);

    // Asynchronous reset while holding
    reset_pulse();
    repeat (8) step(1'b0, 1'b0, 32'h0);
    reset_pulse();
    repeat (3) step(1'b1, 1'b0, 32'h0);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 79) == 0) reset_pulse();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_prefetch.md
# inst_prefetch

Instruction prefetch stage between the `cpu` fetch logic and `Inst_rom` in the minimal SoPC. It owns the fetch PC and drives the ROM chip-enable and address. Returned words go into a small FIFO of {pc, inst} pairs, which the CPU's decode stage drains through a valid/ready handshake. A redirect input (branch/jump) flushes the queue and restarts fetch at a new target.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `DEPTH`, default 4: queue entries; must be a power of two, ≥2.
- `clk` in 1: sole clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset (asserted at 0).
- `rom_ce_o` out 1: ROM chip enable (`ChipEnable`/`ChipDisable`).
- `rom_addr_o` out `InstAddrBus` (32): ROM word address (byte address, bits[1:0]=0).
- `rom_data_i` in `InstBus` (32): ROM read data; combinational, valid in the same cycle as `rom_ce_o`/`rom_addr_o`.
- `if_valid_o` out 1: queue head holds a valid instruction.
- `if_pc_o` out 32: PC of the head entry.
- `if_inst_o` out 32: instruction of the head entry.
- `id_ready_i` in 1: consumer accepts the head this cycle.
- `redirect_i` in 1: flush the queue and restart fetch.
- `redirect_pc_i` in 32: new fetch target; bits[1:0] are ignored (forced to 0).

## Operation
- State machine `ipf_state`:
  - S_BOOT: first cycle after `rst` deasserts. `rom_ce_o`=0. Goes to S_RUN unconditionally.
  - S_RUN: fetching. Goes to S_HOLD when the push this cycle brings `count` to DEPTH.
  - S_HOLD: queue full, `rom_ce_o`=0. Returns to S_RUN on any pop or redirect.
- Fetch happens when state is S_RUN, `count`<DEPTH and `redirect_i`=0. In that cycle:
  - `rom_ce_o`=1 and `rom_addr_o`=`fetch_pc`.
  - At the edge, {`fetch_pc`, `rom_data_i`} is pushed and `fetch_pc` += 4.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0.
- Whenever `rom_ce_o`=0, `rom_addr_o` is driven to `ZeroWord`.
- Pop happens on `if_valid_o` && `id_ready_i`; the read pointer advances at the edge.
- `if_valid_o` = (`count`≠0). `if_pc_o`/`if_inst_o` read the head entry combinationally from registers. When the queue is empty they hold `ZeroWord`.
- Push eligibility uses `count` before any pop (no push-through). With a full queue, a pop that cycle does not enable a push; fetch resumes the following cycle.
- Simultaneous push and pop: `count` is unchanged and both pointers advance, each wrapping modulo DEPTH.
- Redirect (`redirect_i`=1) is handled at the edge:
  - `count`, rd_ptr and wr_ptr clear to 0.
  - `fetch_pc` <= {`redirect_pc_i`[31:2], 2'b00}.
  - State goes to S_RUN.
  - No fetch occurs that cycle.
  - A pop in the same cycle counts as delivered (the consumer keeps it); the rest of the queue is discarded.
- Reset asserted at any time (including mid-fetch or while S_HOLD) immediately clears state, pointers, `count` and outputs, and sets `fetch_pc` to `RESET_PC`.

## Timing
- Reset values:
  - `rom_ce_o`=0, `rom_addr_o`=0.
  - `if_valid_o`=0, `if_pc_o`=0, `if_inst_o`=0.
  - State is S_BOOT.
- Fetch-to-output latency is 1 cycle: a word fetched in cycle N is at the head in cycle N+1 if the queue was empty.
- First instruction after reset release: fetched in cycle 1 (cycle 0 is S_BOOT), visible in cycle 2.
- Redirect penalty: redirect in cycle N → target fetched in N+1 → `if_valid_o` in N+2.
- Steady state with `id_ready_i`=1 sustains one instruction per cycle.

## Configuration
- `IPF_PERF_EN` defined:
  - Adds outputs `perf_fetch_cnt_o` [31:0], which counts cycles with `rom_ce_o`=1.
  - Adds outputs `perf_flush_cnt_o` [31:0], which counts redirects that discarded at least one entry.
  - Both counters reset to 0, wrap at 2^32, and are cleared only by `rst`.
- `IPF_PERF_EN` undefined: the ports and counters are absent and the block is otherwise identical.

## Structure
- In `Defines.vh`: `InstAddrBus`, `InstBus`, `ZeroWord`, `ChipEnable`/`ChipDisable`, `ipf_state` encodings (`IPF_BOOT`, `IPF_RUN`, `IPF_HOLD`), and `IPF_PERF_EN` documentation.
- Sub-module `ipf_queue`: the DEPTH-entry {pc, inst} register FIFO with push, pop, flush, count, full and empty. `inst_prefetch` holds the PC, the FSM and the ROM interface.

## Test plan
- Reset release, ROM word i = 32'h1000_0000+i, `id_ready_i`=1 → `rom_ce_o` rises in cycle 1; `if_valid_o` rises in cycle 2 with pc 0, then pc 4, 8, 12 … with one instruction per cycle.
- `id_ready_i`=0 from reset → exactly 4 fetches (pc 0–12), then S_HOLD with `rom_ce_o`=0. Set `id_ready_i`=1 for 1 cycle → pop pc 0; pc 16 is fetched the next cycle.
- Queue holding 3 entries, `redirect_i`=1 with `redirect_pc_i`=32'h0000_0103 and `id_ready_i`=1 → head consumed; next cycle `if_valid_o`=0 and `rom_addr_o`=32'h100; following cycle head pc=32'h100.
- `RESET_PC`=32'hFFFF_FFF8 → fetches at FFFF_FFF8, FFFF_FFFC, then 0000_0000.
- `rst` driven to 0 asynchronously between edges while in S_HOLD → all outputs 0 immediately; after release, fetch restarts at `RESET_PC`.
- With `IPF_PERF_EN`: 10 fetch cycles plus one redirect while non-empty → `perf_fetch_cnt_o`=10 and `perf_flush_cnt_o`=1.
